i2s_codec_master: RTL

Codec-side end of the audio serial link: generates bit clock and left/right clocks as bus master, serializes parallel samples onto the ADC data line, and deserializes the DAC data line into parallel samples. It sits on the FPGA in place of the external codec. This lets the audio controller be exercised in loopback and simulation with no board codec. Frame format is left-justified, 2×DATA_WIDTH bit clocks per frame.

---
 rtl/i2s_codec_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2s_codec_master.sv
// i2s_codec_master: codec-side end of a left-justified audio serial link.
// Acts as bus master: it generates AUD_BCLK and the LR clocks, shifts the
// held tx pair out on AUD_ADCDAT, and collects AUD_DACDAT into rx pairs.
// A frame is 2*DATA_WIDTH bit clocks; left channel first while LRCK=1.
// Optional feature: define I2S_LOOPBACK_EN to add a 'loopback' input that
// routes the internal AUD_ADCDAT bit into the rx shifter, one frame at a time.
module i2s_codec_master #(
  parameter int DATA_WIDTH = 32,
  parameter int HALF_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef I2S_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  output logic                  AUD_BCLK,
  output logic                  AUD_ADCLRCK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_ADCDAT,
  input  logic                  AUD_DACDAT
);

  localparam int FRAME_BITS = 2 * DATA_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(HALF_DIV);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] HALF_BITS = BIT_W'(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic                  bclk_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  lrck_q;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] hold_data;
  logic                  hold_empty;
  logic                  underrun_q;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  rx_done;
  logic [DATA_WIDTH-1:0] rx_left_q;
  logic [DATA_WIDTH-1:0] rx_right_q;
  logic                  rx_valid_q;

  logic                  edge_cycle;
  logic                  bclk_fall;
  logic                  bclk_rise;
  logic                  frame_start;
  logic [BIT_W-1:0]      bit_next;
  logic                  rx_bit;

  // Edge strobes: the divider's terminal count is the cycle BCLK toggles;
  // the current BCLK level says which direction that toggle goes.
  assign edge_cycle  = (div_cnt == DIV_LAST);
  assign bclk_fall   = edge_cycle & bclk_q;
  assign bclk_rise   = edge_cycle & ~bclk_q;
  assign frame_start = bclk_fall & (bit_cnt == LAST_BIT);
  assign bit_next    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);

`ifdef I2S_LOOPBACK_EN
  logic lb_q;

  // Loopback select is latched once per frame so a mid-frame change
  // never splices two sources into one rx pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      lb_q <= 1'b0;
    end else if (frame_start) begin
      lb_q <= loopback;
    end
  end

  assign rx_bit = lb_q ? tx_shift[FRAME_BITS-1] : AUD_DACDAT;
`else
  assign rx_bit = AUD_DACDAT;
`endif

  // Bit-clock divider: toggle BCLK every HALF_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk_q  <= 1'b1;
    end else if (edge_cycle) begin
      div_cnt <= '0;
      bclk_q  <= ~bclk_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Bit position and LR clock advance together on BCLK falling edges.
  // Reset parks bit_cnt on the last bit so the first fall starts frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= LAST_BIT;
      lrck_q  <= 1'b0;
    end else if (bclk_fall) begin
      bit_cnt <= bit_next;
      lrck_q  <= (bit_next < HALF_BITS);
    end
  end

  // Tx handshake: a pair {tx_left, tx_right} transfers on any cycle where
  // tx_valid and tx_ready are both high; tx_ready is high exactly while the
  // holding register is empty, and tx_valid may not be withdrawn-and-changed
  // expectations apply only on that transfer cycle.
  // Frame start consumes the state held before this cycle, so a pair
  // accepted on the frame-start cycle itself waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_empty <= 1'b1;
      hold_data  <= '0;
      tx_shift   <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (frame_start) begin
        if (!hold_empty) begin
          tx_shift   <= hold_data;
          hold_empty <= 1'b1;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end else if (bclk_fall) begin
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end
      if (tx_valid && hold_empty) begin
        hold_data  <= {tx_left, tx_right};
        hold_empty <= 1'b0;
      end
    end
  end

  // Rx shifter samples on BCLK rising edges; the pair is published one
  // cycle after the rising edge of the frame's last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift   <= '0;
      rx_done    <= 1'b0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_done    <= 1'b0;
      rx_valid_q <= 1'b0;
      if (bclk_rise) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], rx_bit};
        rx_done  <= (bit_cnt == LAST_BIT);
      end
      if (rx_done) begin
        rx_left_q  <= rx_shift[FRAME_BITS-1:DATA_WIDTH];
        rx_right_q <= rx_shift[DATA_WIDTH-1:0];
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign tx_ready    = hold_empty;
  assign tx_underrun = underrun_q;
  assign rx_left     = rx_left_q;
  assign rx_right    = rx_right_q;
  assign rx_valid    = rx_valid_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_ADCLRCK = lrck_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_ADCDAT  = tx_shift[FRAME_BITS-1];

endmodule
